// File: rtl/fetch_redirect_pkg.sv
// fetch_redirect_pkg
// Shared definitions for the fetch redirect block: the per-lane FSM state type,
// the PC width, the fetch increments and the fetch-mode encodings.
// Optional feature macro used by the block: BRANCH_STATS_EN (taken-branch counters).
package fetch_redirect_pkg;

    // Per-lane FSM states
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } lane_state_e;

    localparam int PC_W = 32;

    // Bubble counter width, enough for FLUSH_CYCLES up to 7
    localparam int FLUSH_CNT_W = 3;

    localparam logic [PC_W-1:0] PC_INC_SPLIT   = 32'd4;
    localparam logic [PC_W-1:0] PC_INC_UNIFIED = 32'd8;

    localparam logic MODE_SPLIT   = 1'b0;
    localparam logic MODE_UNIFIED = 1'b1;

    // Branch targets are forced onto a word boundary
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] t);
        return {t[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_lane.sv
// redirect_lane
// One fetch lane: PC register, RUN/FLUSH state machine, bubble counter and the
// one-cycle flush pulse. Optional taken-redirect counter under BRANCH_STATS_EN.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   inc               PC step applied on an accepted fetch
//   fetch_ready       instruction memory accepts this cycle's fetch
//   redirect_req      taken branch presented by the lane (ignored in FLUSH)
//   target            branch target
//   force_flush       mode change: flush regardless of lane state
//   force_load_en/pc  on a forced flush, load this PC (unless a redirect loads the target)
//   run, pc, flush    lane is fetching, current PC, flush pulse
//   taken_cnt         saturating count of accepted redirects (BRANCH_STATS_EN only)
module redirect_lane
    import fetch_redirect_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] inc,
    input  logic            fetch_ready,
    input  logic            redirect_req,
    input  logic [PC_W-1:0] target,
    input  logic            force_flush,
    input  logic            force_load_en,
    input  logic [PC_W-1:0] force_load_pc,
    output logic            run,
    output logic [PC_W-1:0] pc,
    output logic            flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [PC_W-1:0] taken_cnt
`endif
);

    lane_state_e            state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic                   flush_q, flush_d;
    logic                   redirect;

    // Branches only count while the lane is fetching
    assign redirect = (state_q == ST_RUN) && redirect_req;

    // Next-state logic. A forced flush wins over everything except that a
    // same-cycle redirect still loads its target. The counter is loaded with
    // FLUSH_CYCLES-1 so the lane spends exactly FLUSH_CYCLES cycles in FLUSH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        if (force_flush) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            flush_d = 1'b1;
            if (redirect) begin
                pc_d = align_pc(target);
            end else if (force_load_en) begin
                pc_d = force_load_pc;
            end
        end else if (state_q == ST_RUN) begin
            if (redirect) begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
                flush_d = 1'b1;
                pc_d    = align_pc(target);
            end else if (fetch_ready) begin
                pc_d = pc_q + inc;
            end
        end else begin
            if (cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Lane state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign run   = (state_q == ST_RUN);
    assign pc    = pc_q;
    assign flush = flush_q;

`ifdef BRANCH_STATS_EN
    logic [PC_W-1:0] taken_cnt_q, taken_cnt_d;

    // Counts redirects that act as redirects; a mode change pre-empts them
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (redirect && !force_flush && (taken_cnt_q != '1)) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
        end
    end

    // Saturating statistics counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: rtl/fetch_redirect.sv
// fetch_redirect
// Two-lane fetch PC generator with branch redirect and flush bubbles.
// mode = 1 (unified): lane A drives both fetch slots (A at pc, B at pc+4, step 8).
// mode = 0 (split):   lanes fetch independently with step 4.
// A change of mode flushes both lanes.
// Optional macro: BRANCH_STATS_EN adds taken_cntA / taken_cntB.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   mode                            fetch mode
//   branch_valid*/branch_taken*/target*  resolved branch per lane
//   fetch_ready                     instruction memory accepts this cycle's fetch
//   fetch_valid*/fetch_pc*          fetch request per lane
//   flush*                          one-cycle squash pulse per lane
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC_A   = 32'h0000_0000,
    parameter logic [PC_W-1:0] RESET_PC_B   = 32'h0000_1000,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            branch_validA,
    input  logic            branch_validB,
    input  logic            branch_takenA,
    input  logic            branch_takenB,
    input  logic [PC_W-1:0] targetA,
    input  logic [PC_W-1:0] targetB,
    input  logic            fetch_ready,
    output logic            fetch_validA,
    output logic            fetch_validB,
    output logic [PC_W-1:0] fetch_pcA,
    output logic [PC_W-1:0] fetch_pcB,
    output logic            flushA,
    output logic            flushB
`ifdef BRANCH_STATS_EN
    ,
    output logic [PC_W-1:0] taken_cntA,
    output logic [PC_W-1:0] taken_cntB
`endif
);

    logic            mode_q, mode_d;
    logic            mode_change;
    logic            unified_q;
    logic [PC_W-1:0] inc_a;
    logic            req_a, req_b;
    logic            load_b;
    logic            run_a, run_b, flush_a, flush_b;
    logic [PC_W-1:0] pc_a, pc_b;

    always_comb begin
        mode_d = mode;
    end

    // Registered copy of mode; reset takes the current mode so no flush follows reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= mode;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign mode_change = (mode != mode_q);
    assign unified_q   = (mode_q == MODE_UNIFIED);
    assign inc_a       = unified_q ? PC_INC_UNIFIED : PC_INC_SPLIT;
    assign req_a       = branch_validA & branch_takenA;
    // Lane B has no branches of its own while lane A fetches for both slots
    assign req_b       = branch_validB & branch_takenB & ~unified_q;
    // Entering split restarts lane B from its reset PC
    assign load_b      = mode_change & (mode == MODE_SPLIT);

    redirect_lane #(
        .RESET_PC     (RESET_PC_A),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_lane_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc           (inc_a),
        .fetch_ready   (fetch_ready),
        .redirect_req  (req_a),
        .target        (targetA),
        .force_flush   (mode_change),
        .force_load_en (1'b0),
        .force_load_pc (RESET_PC_A),
        .run           (run_a),
        .pc            (pc_a),
        .flush         (flush_a)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt     (taken_cntA)
`endif
    );

    redirect_lane #(
        .RESET_PC     (RESET_PC_B),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_lane_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc           (PC_INC_SPLIT),
        .fetch_ready   (fetch_ready),
        .redirect_req  (req_b),
        .target        (targetB),
        .force_flush   (mode_change),
        .force_load_en (load_b),
        .force_load_pc (RESET_PC_B),
        .run           (run_b),
        .pc            (pc_b),
        .flush         (flush_b)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt     (taken_cntB)
`endif
    );

    // In unified mode lane B's slot is a shadow of lane A
    assign fetch_validA = run_a;
    assign fetch_pcA    = pc_a;
    assign flushA       = flush_a;
    assign fetch_validB = unified_q ? run_a : run_b;
    assign fetch_pcB    = unified_q ? (pc_a + PC_INC_SPLIT) : pc_b;
    assign flushB       = unified_q ? flush_a : flush_b;

endmodule

// File: tb/tb_fetch_redirect.sv
// tb_fetch_redirect
// Self-checking bench for fetch_redirect: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle against
// a behavioural model of the lane PCs and bubble counts.
module tb_fetch_redirect;

    localparam int unsigned FLUSH_N = 2;
    localparam logic [31:0] RST_A   = 32'h0000_0000;
    localparam logic [31:0] RST_B   = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        branch_validA, branch_validB, branch_takenA, branch_takenB;
    logic [31:0] targetA, targetB;
    logic        fetch_ready;
    logic        fetch_validA, fetch_validB, flushA, flushB;
    logic [31:0] fetch_pcA, fetch_pcB;

    int nChecks = 0;
    int nFails  = 0;
    int cycle   = 0;

    // Behavioural model: PC per lane, bubbles left before fetching resumes,
    // flush pulse per lane, registered mode
    bit [31:0] mPc[2];
    int        mBubble[2];
    bit        mFlush[2];
    bit        mModeQ;

    // Free-running clock
    always #5 clk = ~clk;

    fetch_redirect #(
        .RESET_PC_A   (RST_A),
        .RESET_PC_B   (RST_B),
        .FLUSH_CYCLES (FLUSH_N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (mode),
        .branch_validA (branch_validA),
        .branch_validB (branch_validB),
        .branch_takenA (branch_takenA),
        .branch_takenB (branch_takenB),
        .targetA       (targetA),
        .targetB       (targetB),
        .fetch_ready   (fetch_ready),
        .fetch_validA  (fetch_validA),
        .fetch_validB  (fetch_validB),
        .fetch_pcA     (fetch_pcA),
        .fetch_pcB     (fetch_pcB),
        .flushA        (flushA),
        .flushB        (flushB)
    );

    function automatic bit [31:0] alignTarget(input bit [31:0] t);
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees
    task automatic modelStep();
        bit [1:0]  nf;
        bit        v, t;
        bit [31:0] tg, step;
        nf = 2'b00;
        if (!rst_n) begin
            mPc[0] = RST_A;
            mPc[1] = RST_B;
            mBubble[0] = 0;
            mBubble[1] = 0;
            mFlush[0] = 1'b0;
            mFlush[1] = 1'b0;
            mModeQ = mode;
            return;
        end
        if (mode != mModeQ) begin
            if (mBubble[0] == 0 && branch_validA && branch_takenA) mPc[0] = alignTarget(targetA);
            if (mode == 1'b0) mPc[1] = RST_B;
            mBubble[0] = FLUSH_N;
            mBubble[1] = FLUSH_N;
            nf = 2'b11;
            mModeQ = mode;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (i == 1 && mModeQ) continue;
                v    = (i == 0) ? branch_validA : branch_validB;
                t    = (i == 0) ? branch_takenA : branch_takenB;
                tg   = (i == 0) ? targetA : targetB;
                step = (i == 0 && mModeQ) ? 32'd8 : 32'd4;
                if (mBubble[i] > 0) begin
                    mBubble[i]--;
                end else if (v && t) begin
                    mPc[i] = alignTarget(tg);
                    mBubble[i] = FLUSH_N;
                    nf[i] = 1'b1;
                end else if (fetch_ready) begin
                    mPc[i] = mPc[i] + step;
                end
            end
        end
        mFlush[0] = nf[0];
        mFlush[1] = nf[1];
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput();
        logic        expValidB, expFlushB;
        logic [31:0] expPcB;
        if (mModeQ) begin
            expValidB = (mBubble[0] == 0);
            expPcB    = mPc[0] + 32'd4;
            expFlushB = mFlush[0];
        end else begin
            expValidB = (mBubble[1] == 0);
            expPcB    = mPc[1];
            expFlushB = mFlush[1];
        end
        checkVal("fetch_validA", 32'(fetch_validA), 32'(mBubble[0] == 0));
        checkVal("fetch_pcA", fetch_pcA, mPc[0]);
        checkVal("flushA", 32'(flushA), 32'(mFlush[0]));
        checkVal("fetch_validB", 32'(fetch_validB), 32'(expValidB));
        checkVal("fetch_pcB", fetch_pcB, expPcB);
        checkVal("flushB", 32'(flushB), 32'(expFlushB));
    endtask

    // One clock: edge, model update, then sample on the falling edge
    task automatic runCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        cycle++;
        checkOutput();
    endtask

    task automatic clearBranches();
        branch_validA = 1'b0;
        branch_takenA = 1'b0;
        branch_validB = 1'b0;
        branch_takenB = 1'b0;
    endtask

    task automatic setBranchA(input logic [31:0] tgt);
        branch_validA = 1'b1;
        branch_takenA = 1'b1;
        targetA       = tgt;
    endtask

    // Random traffic: frequent branches, occasional mode flips and resets
    task automatic applyStimulus();
        rst_n         = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, 31) == 0) mode = ~mode;
        branch_validA = ($urandom_range(0, 3) == 0);
        branch_takenA = $urandom_range(0, 1) == 1;
        branch_validB = ($urandom_range(0, 3) == 0);
        branch_takenB = $urandom_range(0, 1) == 1;
        targetA       = $urandom();
        targetB       = $urandom();
        fetch_ready   = ($urandom_range(0, 3) != 0);
    endtask

    // Directed scenarios first, then random traffic, then the summary
    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        clearBranches();
        targetA = '0;
        targetB = '0;
        fetch_ready = 1'b0;
        @(negedge clk);

        // Reset state and first cycle after release
        runCycle();
        rst_n = 1'b1;
        checkVal("rst_pcA", fetch_pcA, 32'h0);
        checkVal("rst_pcB", fetch_pcB, 32'h1000);
        checkVal("rst_validA", 32'(fetch_validA), 32'd1);

        // Split sequential fetch
        fetch_ready = 1'b1;
        runCycle();
        checkVal("seq_pcA1", fetch_pcA, 32'h4);
        checkVal("seq_pcB1", fetch_pcB, 32'h1004);
        runCycle();
        checkVal("seq_pcA2", fetch_pcA, 32'h8);
        checkVal("seq_pcB2", fetch_pcB, 32'h1008);

        // Split redirect to 0x203, then a branch during FLUSH is ignored
        setBranchA(32'h203);
        runCycle();
        checkVal("redir_flushA", 32'(flushA), 32'd1);
        checkVal("redir_pcA", fetch_pcA, 32'h200);
        checkVal("redir_validA0", 32'(fetch_validA), 32'd0);
        setBranchA(32'h80);
        runCycle();
        checkVal("redir_validA1", 32'(fetch_validA), 32'd0);
        checkVal("redir_flushA1", 32'(flushA), 32'd0);
        clearBranches();
        runCycle();
        checkVal("redir_resume_valid", 32'(fetch_validA), 32'd1);
        checkVal("redir_resume_pcA", fetch_pcA, 32'h200);

        // Unified redirect to 0x40; lane B branch ignored
        rst_n = 1'b0;
        mode  = 1'b1;
        runCycle();
        rst_n = 1'b1;
        setBranchA(32'h40);
        branch_validB = 1'b1;
        branch_takenB = 1'b1;
        targetB = 32'h900;
        runCycle();
        checkVal("uni_flushA", 32'(flushA), 32'd1);
        checkVal("uni_flushB", 32'(flushB), 32'd1);
        clearBranches();
        runCycle();
        runCycle();
        checkVal("uni_pcA", fetch_pcA, 32'h40);
        checkVal("uni_pcB", fetch_pcB, 32'h44);
        checkVal("uni_validB", 32'(fetch_validB), 32'd1);
        runCycle();
        checkVal("uni_pcA2", fetch_pcA, 32'h48);
        checkVal("uni_pcB2", fetch_pcB, 32'h4C);

        // Reach pcA = 0x100 in unified, then switch to split
        fetch_ready = 1'b0;
        setBranchA(32'h100);
        runCycle();
        clearBranches();
        runCycle();
        runCycle();
        checkVal("mc_pre_pcA", fetch_pcA, 32'h100);
        mode = 1'b0;
        runCycle();
        checkVal("mc_flushA", 32'(flushA), 32'd1);
        checkVal("mc_flushB", 32'(flushB), 32'd1);
        checkVal("mc_validA", 32'(fetch_validA), 32'd0);
        runCycle();
        runCycle();
        checkVal("mc_pcA", fetch_pcA, 32'h100);
        checkVal("mc_pcB", fetch_pcB, 32'h1000);
        checkVal("mc_validB", 32'(fetch_validB), 32'd1);

        // Reset during FLUSH
        fetch_ready = 1'b1;
        setBranchA(32'h300);
        runCycle();
        clearBranches();
        rst_n = 1'b0;
        runCycle();
        rst_n = 1'b1;
        checkVal("rstfl_pcA", fetch_pcA, 32'h0);
        checkVal("rstfl_pcB", fetch_pcB, 32'h1000);
        checkVal("rstfl_validA", 32'(fetch_validA), 32'd1);
        checkVal("rstfl_flushA", 32'(flushA), 32'd0);

        // Simultaneous split redirects
        setBranchA(32'h500);
        branch_validB = 1'b1;
        branch_takenB = 1'b1;
        targetB = 32'h607;
        runCycle();
        checkVal("dual_pcA", fetch_pcA, 32'h500);
        checkVal("dual_pcB", fetch_pcB, 32'h604);
        checkVal("dual_flushB", 32'(flushB), 32'd1);
        clearBranches();
        runCycle();
        runCycle();

        // Redirect with fetch_ready low, then PC wrap
        fetch_ready = 1'b0;
        setBranchA(32'hFFFF_FFFF);
        runCycle();
        clearBranches();
        runCycle();
        runCycle();
        checkVal("wrap_pre_pcA", fetch_pcA, 32'hFFFF_FFFC);
        fetch_ready = 1'b1;
        runCycle();
        checkVal("wrap_pcA", fetch_pcA, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            runCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
